// File: rtl/sa_input_requester.sv
// Input-side requester for the 4-port switch allocator: buffers flits and presents the head
// flit's destination until granted. Optional grant-timeout watchdog: define SA_REQ_TIMEOUT_EN.

`ifndef EMPTY
`define EMPTY 3'd0
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT 3'd1
`endif
`ifndef OUT_X2_PORT
`define OUT_X2_PORT 3'd2
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT 3'd3
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd4
`endif

module sa_input_requester #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_dst,
  output logic              in_ready,
  output logic [2:0]        req_dst,
  output logic              req_en,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [AW:0]       count,
  output logic              stall_err
);

  typedef enum logic [1:0] {StIdle, StReq, StClear} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [2:0]        mem_dst  [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]       count_q, count_d, remaining_old;
  logic [2:0]        req_dst_q, req_dst_d, next_head_dst;
  logic              req_en_q, req_en_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              push, pop;

  assign in_ready = (count_q != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StReq) && grant && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Head after this cycle: an older entry if one survives the pop, else the flit arriving now.
  assign rd_next       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign remaining_old = count_q - (AW+1)'(pop);
  assign next_head_dst = (remaining_old != '0) ? mem_dst[rd_next] : in_dst;

  always_comb begin
    state_d   = state_q;
    req_dst_d = req_dst_q;
    req_en_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_dst_d = `EMPTY;
        if (count_d != '0) begin
          state_d   = StReq;
          req_dst_d = next_head_dst;
          req_en_d  = 1'b1;
        end
      end
      StReq: begin
        if (pop) begin
          req_en_d = 1'b1;
          if (count_d != '0) begin
            req_dst_d = next_head_dst;
          end else begin
            state_d   = StClear;
            req_dst_d = `EMPTY;
          end
        end
      end
      StClear: begin
        state_d   = StIdle;
        req_dst_d = `EMPTY;
      end
      default: begin
        state_d   = StIdle;
        req_dst_d = `EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_dst_q   <= `EMPTY;
      req_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_dst_q   <= req_dst_d;
      req_en_q    <= req_en_d;
      out_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        out_data_q <= mem_data[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_dst[wr_ptr_q]  <= in_dst;
    end
  end

`ifdef SA_REQ_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] wait_q;
  logic          stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else if ((state_q == StReq) && !grant) begin
      if (wait_q != TW'(TIMEOUT)) wait_q <= wait_q + TW'(1);
      if (wait_q + TW'(1) == TW'(TIMEOUT)) stall_q <= 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  assign stall_err = stall_q;
`else
  assign stall_err = 1'b0;
`endif

  assign req_dst   = req_dst_q;
  assign req_en    = req_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule
